// File: rtl/hv_fifo_p_if.sv
// rtl/hv_fifo_p_if.sv - push/pop/status bundle for the hv_fifo_p I/O queue
interface hv_fifo_p_if #(
  parameter int WIDTH      = 12,
  parameter int DEPTH_LOG2 = 8
);

  // producer side
  logic                  wr_en;
  logic [WIDTH-1:0]      wr_data;

  // consumer side
  logic                  rd_adv;
  logic [WIDTH-1:0]      rd_data;

  // status and error handling
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;

  // datapath / testbench side that drives the queue
  modport master (
    output wr_en, wr_data, rd_adv, clr_err,
    input  rd_data, empty, full, almost_full, count, overflow, underflow
  );

  // the queue itself
  modport slave (
    input  wr_en, wr_data, rd_adv, clr_err,
    output rd_data, empty, full, almost_full, count, overflow, underflow
  );

endinterface

// File: rtl/hv_fifo_p.sv
// rtl/hv_fifo_p.sv - parametrised single-clock FIFO with registered head word
module hv_fifo_p #(
  parameter int               WIDTH       = 12,
  parameter int               DEPTH_LOG2  = 8,
  parameter logic [WIDTH-1:0] EMPTY_VALUE = '0,
  parameter int               AFULL_LEVEL = (1 << DEPTH_LOG2) - 4
) (
  input  logic       clk,
  input  logic       rst,
  hv_fifo_p_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0]         CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_AFULL = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0]         CNT_ZERO  = '0;
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  // storage is never reset; only pointers and count qualify its contents
  logic [WIDTH-1:0]      mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] wp_q, wp_d;
  logic [DEPTH_LOG2-1:0] rp_q, rp_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  is_empty;
  logic                  is_full;
  logic                  pop;
  logic                  push;
  logic                  mem_we;

  // accept/reject decisions and next state, all from pre-edge count and pointers
  always_comb begin
    is_empty    = (count_q == CNT_ZERO);
    is_full     = (count_q == CNT_FULL);
    pop         = bus.rd_adv && !is_empty;
    // a pop in the same cycle frees the slot, so a full queue still accepts
    push        = bus.wr_en && (!is_full || pop);
    mem_we      = push && !rst;

    wp_d        = push ? (wp_q + PTR_ONE) : wp_q;
    rp_d        = pop  ? (rp_q + PTR_ONE) : rp_q;

    count_d     = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // head word being popped this cycle, read before any same-cycle write lands
    rd_data_d   = is_empty ? EMPTY_VALUE : mem_q[rp_q];

    // setting wins over clearing so an error in the clear cycle is not lost
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.wr_en && !push) begin
      overflow_d = 1'b1;
    end
    if (bus.rd_adv && is_empty) begin
      underflow_d = 1'b1;
    end
  end

  // control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      rd_data_q   <= EMPTY_VALUE;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // array write port; writes in the reset cycle are discarded
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wp_q] <= bus.wr_data;
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.count       = count_q;
  assign bus.empty       = (count_q == CNT_ZERO);
  assign bus.full        = (count_q == CNT_FULL);
  assign bus.almost_full = (count_q >= CNT_AFULL);
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule
